regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the generic register file between NUM_REQ requesters. Each requester offers an address/data write with a valid/ready handshake. The winner is registered into an output stage that drives the register file's write-enable, write-address and data-in pins directly. An optional per-requester lock grants back-to-back writes, bounded by MAX_LOCK, for multi-register updates.

## Interface
- WORD_LENGTH, 8, data width; matches the register file word.
- REG_AMOUNT, 8, register count; AW = $clog2(REG_AMOUNT).
- NUM_REQ, 4, requester count, ≥ 2; SW = $clog2(NUM_REQ).
- MAX_LOCK, 16, maximum consecutive grants under one lock, ≥ 1; 1 disables locking.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset rst_n, synchronous, active-low; clock clk.
- req_valid  in  NUM_REQ  requester k offers a write.
- req_lock  in  NUM_REQ  requester k asks to keep the port after this grant.
- req_addr  in  NUM_REQ*AW  packed; slice k = [k*AW +: AW].
- req_data  in  NUM_REQ*WORD_LENGTH  packed; slice k = [k*WORD_LENGTH +: WORD_LENGTH].
- req_ready  out  NUM_REQ  combinational grant, at most one bit set.
- wr_en  out  1  registered write enable to the register file.
- wr_addr  out  AW  registered write address.
- wr_data  out  WORD_LENGTH  registered write data.
- wr_src  out  SW  index of the requester that owns the current wr_en.

## Operation
- Handshake on requester k: req_valid[k] & req_ready[k] at a rising edge. Requesters hold valid, addr, data and lock stable until the handshake.
- req_ready[k] is high only if req_valid[k] is high and k is the winner. It is forced to 0 while rst_n = 0.
- State:
  - ptr (SW bits): priority pointer.
  - lock_act: lock is held.
  - owner (SW bits): lock holder.
  - lock_cnt: counts 1..MAX_LOCK.
- Winner selection, evaluated every cycle:
  - Locked: if lock_act and req_valid[owner], the winner is owner. All other requesters are blocked.
  - Unlocked: otherwise the winner is the first valid index found by scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Idle: no valid requester means no grant.
- On a grant to k:
  - ptr <= (k+1) mod NUM_REQ, including grants made under lock.
- Lock transitions on a grant to k:
  - Acquire: not locked and req_lock[k] = 1 with MAX_LOCK > 1. Then lock_act <= 1, owner <= k, lock_cnt <= 1.
  - Continue: locked, req_lock[k] = 1 and lock_cnt+1 < MAX_LOCK. Then lock_cnt increments.
  - Release: locked and either req_lock[k] = 0 or lock_cnt+1 = MAX_LOCK. Then lock_act <= 0. That grant still completes.
- Lock released by valid drop: if lock_act and req_valid[owner] = 0 in a cycle, lock_act <= 0. Round-robin arbitration applies in that same cycle, starting at ptr = owner+1.
- Output stage, each edge:
  - On a handshake: wr_en <= 1; wr_addr and wr_data take the winner's slices; wr_src <= winner.
  - With no handshake: wr_en <= 0, and wr_addr, wr_data and wr_src hold their previous values.
- Writes are never dropped or merged. Two consecutive writes to the same address both appear on wr_en in order, and the last one wins in the register file.
- Reset values:
  - wr_en = 0, wr_addr = 0, wr_data = 0, wr_src = 0.
  - ptr = 0, lock_act = 0, lock_cnt = 0.
  - req_ready = 0 during reset.

## Timing
- req_ready is combinational from req_valid, req_lock and internal state. There is no combinational path from addr or data to ready.
- Latency:
  - Handshake at edge T puts wr_en = 1 on the port during cycle T..T+1.
  - The register file commits the write at edge T+1.
  - A read of that address issued after edge T+1 returns the new value one cycle later, per the file's registered read.
- Throughput is one write per cycle total. A lone valid requester is granted every cycle.
- Fairness: with all NUM_REQ requesters continuously valid and unlocked, each is granted exactly once every NUM_REQ cycles.
- Worst-case wait for a valid requester is (NUM_REQ-1)*MAX_LOCK cycles.
- Reset mid-operation:
  - A rst_n = 0 edge discards the pending output-stage write; wr_en is 0 after that edge.
  - Any lock and the pointer return to reset state.
  - Requesters must re-present their writes.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with all req_valid = 1. Required: req_ready = 0 throughout; after the first edge wr_en = 0, wr_addr = 0, wr_data = 0, wr_src = 0.
- Round-robin: NUM_REQ = 4, all valid, no lock, data = 8'h10+k, addr = k, for 8 cycles. Required: wr_src sequence 0,1,2,3,0,1,2,3 starting one cycle after the first grant, with wr_data matching each source.
- Lock: requester 2 asserts lock for 3 writes (lock = 1,1,0) while 0, 1 and 3 are valid. Required: three consecutive grants to 2, then grants resume at 3, 0, 1.
- Lock bound: MAX_LOCK = 4, requester 1 holds req_lock = 1 and stays valid while 0 and 2 are valid. Required: exactly 4 grants to 1, then 2 is granted next.
- Lock drop: requester 0 locked, deasserts req_valid for one cycle while 3 is valid. Required: 3 is granted in that same cycle and the lock is cleared.
- Reset mid-write: handshake (addr 5, data 8'hA5) at edge T, with rst_n = 0 sampled at edge T+1. Required: wr_en = 0 after edge T+1, and a subsequent read of register 5 returns 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the requester side (valid/lock/addr/data in, ready out) and the
//   register-file write port (wr_en/wr_addr/wr_data/wr_src) of the write
//   arbiter.
//
//   modport slave  : the arbiter's view (requests in, grant and write port out)
//   modport master : the requesters'/environment's view (the opposite)
//
//   Packed request vectors: slice k of req_addr is [k*AW +: AW], slice k of
//   req_data is [k*WORD_LENGTH +: WORD_LENGTH].
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
   parameter int WORD_LENGTH = 8,
   parameter int REG_AMOUNT  = 8,
   parameter int NUM_REQ     = 4
);
   localparam int AW = $clog2(REG_AMOUNT);
   localparam int SW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_lock;
   logic [NUM_REQ*AW-1:0]          req_addr;
   logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;

   logic                           wr_en;
   logic [AW-1:0]                  wr_addr;
   logic [WORD_LENGTH-1:0]         wr_data;
   logic [SW-1:0]                  wr_src;

   modport slave (
      input  req_valid, req_lock, req_addr, req_data,
      output req_ready, wr_en, wr_addr, wr_data, wr_src
   );

   modport master (
      output req_valid, req_lock, req_addr, req_data,
      input  req_ready, wr_en, wr_addr, wr_data, wr_src
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Round-robin arbiter sharing the single write port of the register file
//   between NUM_REQ requesters. The winning request is registered into an
//   output stage that drives the register file's write pins directly. A
//   requester may hold the port for up to MAX_LOCK back-to-back grants by
//   asserting its lock bit (MAX_LOCK = 1 disables locking).
//
//   Ports:
//     clk    : clock, all logic on the rising edge
//     rst_n  : synchronous active-low reset
//     bus_if : regfile_write_arbiter_if.slave
//                req_valid/req_lock/req_addr/req_data in, req_ready out
//                (combinational, one-hot or zero), wr_en/wr_addr/wr_data/
//                wr_src out (registered)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int WORD_LENGTH = 8,
   parameter int REG_AMOUNT  = 8,
   parameter int NUM_REQ     = 4,
   parameter int MAX_LOCK    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_write_arbiter_if.slave bus_if
);
   localparam int AW  = $clog2(REG_AMOUNT);
   localparam int SW  = $clog2(NUM_REQ);
   // While locked the count never exceeds MAX_LOCK-1, so this width suffices.
   localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } lock_state_e;

   // (base + off) mod NUM_REQ for off in 0..NUM_REQ-1; one subtraction is enough.
   function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return SW'(sum);
   endfunction

   lock_state_e             r_state, w_state_nxt;
   logic [SW-1:0]           r_owner, w_owner_nxt;
   logic [LCW-1:0]          r_lock_cnt, w_lock_cnt_nxt;
   logic [SW-1:0]           r_ptr;

   logic                    r_wr_en;
   logic [AW-1:0]           r_wr_addr;
   logic [WORD_LENGTH-1:0]  r_wr_data;
   logic [SW-1:0]           r_wr_src;

   logic                    w_locked;
   logic                    w_acquire;
   logic                    w_grant_vld;
   logic [SW-1:0]           w_grant_idx;
   logic [AW-1:0]           w_addr_arr [NUM_REQ];
   logic [WORD_LENGTH-1:0]  w_data_arr [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_addr_arr[k] = bus_if.req_addr[k*AW +: AW];
      assign w_data_arr[k] = bus_if.req_data[k*WORD_LENGTH +: WORD_LENGTH];
   end

   // The lock only binds while its owner keeps offering; a dropped valid
   // falls through to round-robin in the same cycle.
   assign w_locked = (r_state == ST_LOCKED) && bus_if.req_valid[r_owner];

   // -------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default on entry;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      if (w_locked) begin
         w_grant_vld = 1'b1;
         w_grant_idx = r_owner;
      end else begin
         // Scan from the far end back toward ptr so the nearest valid index
         // is the last assignment and therefore the winner.
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus_if.req_valid[wrap_add(r_ptr, i)]) begin
               w_grant_vld = 1'b1;
               w_grant_idx = wrap_add(r_ptr, i);
            end
         end
      end
   end

   assign w_acquire = w_grant_vld && !w_locked && (MAX_LOCK > 1) &&
                      bus_if.req_lock[w_grant_idx];

   assign bus_if.req_ready = (rst_n && w_grant_vld) ? (NUM_REQ'(1) << w_grant_idx) : '0;

   // -------------------------------------------------------------------
   // Lock FSM: next state
   // -------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_lock_cnt_nxt = r_lock_cnt;
      if (w_locked) begin
         // A locked cycle always grants the owner; the grant completes even
         // when it is the one that releases the lock.
         if (bus_if.req_lock[w_grant_idx] && (r_lock_cnt < LOCK_LAST)) begin
            w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
         end else begin
            w_state_nxt = ST_OPEN;
         end
      end else if (w_acquire) begin
         w_state_nxt    = ST_LOCKED;
         w_owner_nxt    = w_grant_idx;
         w_lock_cnt_nxt = LCW'(1);
      end else begin
         w_state_nxt = ST_OPEN;
      end
   end

   // -------------------------------------------------------------------
   // Lock FSM: state register
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_OPEN;
         r_owner    <= '0;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   // -------------------------------------------------------------------
   // Pointer and output stage
   // -------------------------------------------------------------------
   // NOTE: address/data/source registers are reset too, because the write
   // port must present all-zero values after reset, not just wr_en = 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_src  <= '0;
      end else begin
         r_wr_en <= w_grant_vld;
         if (w_grant_vld) begin
            // Advances on locked grants as well, so a released or dropped
            // lock resumes just past its owner.
            r_ptr     <= wrap_add(w_grant_idx, 1);
            r_wr_addr <= w_addr_arr[w_grant_idx];
            r_wr_data <= w_data_arr[w_grant_idx];
            r_wr_src  <= w_grant_idx;
         end
      end
   end

   assign bus_if.wr_en   = r_wr_en;
   assign bus_if.wr_addr = r_wr_addr;
   assign bus_if.wr_data = r_wr_data;
   assign bus_if.wr_src  = r_wr_src;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios (reset, round-robin, lock, lock bound, lock drop,
//   reset mid-write) followed by protocol-respecting random traffic. A
//   reference model tracks pointer/lock ownership as plain integers and
//   predicts req_ready each cycle and the write port after each edge.
//   A small register-file model (reset has priority over writes) consumes
//   the write port.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
   localparam int WL   = 8;
   localparam int RA   = 8;
   localparam int NREQ = 4;
   localparam int MAXL = 4;
   localparam int AW   = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.WORD_LENGTH(WL), .REG_AMOUNT(RA), .NUM_REQ(NREQ)) bus_if ();

   regfile_write_arbiter #(
      .WORD_LENGTH(WL),
      .REG_AMOUNT (RA),
      .NUM_REQ    (NREQ),
      .MAX_LOCK   (MAXL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_if(bus_if)
   );

   // Register file fed by the write port.
   logic [WL-1:0] rf [RA];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RA; i++) rf[i] <= '0;
      end else if (bus_if.wr_en) begin
         rf[bus_if.wr_addr] <= bus_if.wr_data;
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: owner = -1 means no lock held.
   int            m_ptr   = 0;
   int            m_owner = -1;
   int            m_taken = 0;
   logic          e_en    = 1'b0;
   logic [AW-1:0] e_addr  = '0;
   logic [WL-1:0] e_data  = '0;
   int            e_src   = 0;
   int            last_win = -1;

   int lk_exp [8];
   int lb_exp [9];
   int ld_exp [5];
   logic ld_v0 [5];
   logic ld_l0 [5];
   logic ld_v3 [5];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic l,
                          input logic [AW-1:0] a, input logic [WL-1:0] d);
      bus_if.req_valid[k]          = v;
      bus_if.req_lock[k]           = l;
      bus_if.req_addr[k*AW +: AW]  = a;
      bus_if.req_data[k*WL +: WL]  = d;
   endtask

   function automatic int model_winner();
      if (m_owner >= 0 && bus_if.req_valid[m_owner]) return m_owner;
      for (int i = 0; i < NREQ; i++) begin
         int c = (m_ptr + i) % NREQ;
         if (bus_if.req_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_update(input int win);
      logic held;
      if (!rst_n) begin
         m_ptr = 0; m_owner = -1; m_taken = 0;
         e_en = 1'b0; e_addr = '0; e_data = '0; e_src = 0;
         return;
      end
      held = (m_owner >= 0) && bus_if.req_valid[m_owner];
      if (!held) m_owner = -1;
      e_en = (win >= 0);
      if (win >= 0) begin
         e_addr = bus_if.req_addr[win*AW +: AW];
         e_data = bus_if.req_data[win*WL +: WL];
         e_src  = win;
         m_ptr  = (win + 1) % NREQ;
         if (held) begin
            m_taken++;
            if (!bus_if.req_lock[win] || m_taken >= MAXL) m_owner = -1;
         end else if (bus_if.req_lock[win] && MAXL > 1) begin
            m_owner = win;
            m_taken = 1;
         end
      end
   endtask

   // One clock: inputs were driven just after a falling edge; check ready,
   // advance the model, then check the write port after the rising edge.
   task automatic step(input string tag);
      logic [NREQ-1:0] exp_rdy;
      #1;
      last_win = model_winner();
      if (!rst_n) last_win = -1;
      exp_rdy = '0;
      if (last_win >= 0) exp_rdy[last_win] = 1'b1;
      check({tag, "/ready"}, 32'(bus_if.req_ready), 32'(exp_rdy));
      model_update(last_win);
      @(posedge clk);
      @(negedge clk);
      check({tag, "/wr_en"},   32'(bus_if.wr_en),   32'(e_en));
      check({tag, "/wr_addr"}, 32'(bus_if.wr_addr), 32'(e_addr));
      check({tag, "/wr_data"}, 32'(bus_if.wr_data), 32'(e_data));
      check({tag, "/wr_src"},  32'(bus_if.wr_src),  32'(e_src));
   endtask

   task automatic expect_src(input string tag, input int src);
      check({tag, "/grant_en"},  32'(bus_if.wr_en),  32'(1));
      check({tag, "/grant_src"}, 32'(bus_if.wr_src), 32'(src));
   endtask

   task automatic idle_all();
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 1'b0, AW'(k), WL'(0));
   endtask

   task automatic refresh_random();
      for (int k = 0; k < NREQ; k++) begin
         if (!bus_if.req_valid[k] || last_win == k)
            set_req(k, $urandom_range(0, 99) < 65, $urandom_range(0, 2) == 0,
                    AW'($urandom), WL'($urandom));
      end
   endtask

   initial begin
      lk_exp = '{0, 1, 2, 2, 2, 3, 0, 1};
      lb_exp = '{2, 0, 1, 1, 1, 1, 2, 0, 1};
      ld_exp = '{0, 0, 3, 0, 3};
      ld_v0  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ld_l0  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ld_v3  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset held three cycles with every requester offering.
      rst_n = 1'b0;
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b0, AW'(k), WL'(8'h10 + k));
      for (int c = 0; c < 3; c++) step("reset");

      // Round-robin: all valid, no lock.
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step("rr");
         expect_src("rr", i % NREQ);
         check("rr/data", 32'(bus_if.wr_data), 32'(8'h10 + (i % NREQ)));
      end

      // Lock: requester 2 holds for three writes (lock 1,1,0) while all valid.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b0, AW'(k), WL'(8'h20 + k));
         set_req(2, i < 5, (i == 2) || (i == 3), AW'(2), WL'(8'h22));
         step("lock");
         expect_src("lock", lk_exp[i]);
      end

      // Lock bound: requester 1 keeps its lock; 0 and 2 stay valid.
      for (int i = 0; i < 9; i++) begin
         set_req(0, 1'b1, 1'b0, AW'(0), WL'(8'h40));
         set_req(1, 1'b1, 1'b1, AW'(1), WL'(8'h41));
         set_req(2, 1'b1, 1'b0, AW'(2), WL'(8'h42));
         set_req(3, 1'b0, 1'b0, AW'(3), WL'(8'h43));
         step("lockmax");
         expect_src("lockmax", lb_exp[i]);
      end
      idle_all();
      step("idle");

      // Lock drop: requester 0 locked, then drops valid while 3 waits.
      for (int i = 0; i < 5; i++) begin
         set_req(0, ld_v0[i], ld_l0[i], AW'(0), WL'(8'h50));
         set_req(1, 1'b0, 1'b0, AW'(1), WL'(8'h51));
         set_req(2, 1'b0, 1'b0, AW'(2), WL'(8'h52));
         set_req(3, ld_v3[i], 1'b0, AW'(3), WL'(8'h53));
         step("lockdrop");
         expect_src("lockdrop", ld_exp[i]);
      end
      idle_all();
      step("idle");

      // Reset mid-write: handshake at T, reset sampled at T+1.
      set_req(1, 1'b1, 1'b0, AW'(5), WL'(8'hA5));
      step("rmw");
      check("rmw/wr_en_T",   32'(bus_if.wr_en),   32'(1));
      check("rmw/wr_addr_T", 32'(bus_if.wr_addr), 32'(5));
      check("rmw/wr_data_T", 32'(bus_if.wr_data), 32'(8'hA5));
      rst_n = 1'b0;
      step("rmw_rst");
      check("rmw/wr_en_T1", 32'(bus_if.wr_en), 32'(0));
      rst_n = 1'b1;
      idle_all();
      for (int c = 0; c < 3; c++) step("rmw_after");
      check("rmw/rf5", 32'(rf[5]), 32'(0));

      // Random traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         refresh_random();
         rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
